// File: rtl/bram_dp_param.sv
// True-dual-port synchronous RAM with byte enables, optional output register,
// selectable same-port read-during-write mode, collision flag and a clear sweep.

// One read-return pipeline per port: stage 1 captures the array word, an
// optional stage 2 adds a register for timing.
module bram_dp_rdpipe #(
    parameter int DATA_WIDTH = 8,
    parameter int OUT_REG    = 0,
    parameter int WRITE_MODE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  acc_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] old_i,
    input  logic [DATA_WIDTH-1:0] new_i,
    output logic [DATA_WIDTH-1:0] q_o,
    output logic                  rvalid_o
);
    logic [DATA_WIDTH-1:0] d1_q;
    logic                  v1_q;

    // Stage 1: pick old or merged word; NO_CHANGE writes leave q alone and return nothing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d1_q <= '0;
            v1_q <= 1'b0;
        end else begin
            v1_q <= acc_i && !(wr_i && (WRITE_MODE == 2));
            if (acc_i) begin
                if (!wr_i || (WRITE_MODE == 1))
                    d1_q <= old_i;
                else if (WRITE_MODE == 0)
                    d1_q <= new_i;
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic [DATA_WIDTH-1:0] d2_q;
            logic                  v2_q;
            // Stage 2: only advance data on a valid return so q holds otherwise
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    d2_q <= '0;
                    v2_q <= 1'b0;
                end else begin
                    v2_q <= v1_q;
                    if (v1_q)
                        d2_q <= d1_q;
                end
            end
            assign q_o      = d2_q;
            assign rvalid_o = v2_q;
        end else begin : g_noreg
            assign q_o      = d1_q;
            assign rvalid_o = v1_q;
        end
    endgenerate
endmodule

module bram_dp_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDR_WIDTH   = 11,
    parameter int BYTE_WIDTH   = 8,
    parameter int OUT_REG      = 0,
    parameter int WRITE_MODE   = 0,
    parameter int CLEAR_ON_RST = 1,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clear_req,
    output logic                             busy,
    input  logic                             en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_a,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            data_a,
    output logic [DATA_WIDTH-1:0]            q_a,
    output logic                             rvalid_a,
    input  logic                             en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_b,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            data_b,
    output logic [DATA_WIDTH-1:0]            q_b,
    output logic                             rvalid_b,
    output logic                             collision
);
    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {ST_RUN, ST_CLEAR} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cnt_q;
    logic                    busy_q;
    logic                    coll_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    acc_a, acc_b, wr_a, wr_b;
    logic [DATA_WIDTH-1:0]   old_a, old_b, new_a, new_b;

    assign acc_a = (state_q == ST_RUN) && en_a;
    assign acc_b = (state_q == ST_RUN) && en_b;
    assign wr_a  = |we_a;
    assign wr_b  = |we_b;
    // Array read before this edge's writes: cross-port reads see the old word
    assign old_a = mem[addr_a];
    assign old_b = mem[addr_b];

    // Per-port merged word: own enabled lanes replaced, others kept
    always_comb begin
        new_a = old_a;
        new_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (we_a[i]) new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (we_b[i]) new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
    end

    // Sweep/run control; sweep ends on the edge that writes the last address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_RUN;
            busy_q  <= (CLEAR_ON_RST != 0);
            cnt_q   <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    cnt_q <= cnt_q + ADDR_WIDTH'(1);
                    if (&cnt_q) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (clear_req) begin
                        cnt_q   <= '0;
                        state_q <= ST_CLEAR;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Array writes; A assigned last so it wins any lane both ports enable
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[cnt_q] <= CLEAR_VALUE;
        end else begin
            for (int i = 0; i < NB; i++) begin
                if (en_b && we_b[i])
                    mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
                if (en_a && we_a[i])
                    mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // One-cycle flag when both ports write the same word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            coll_q <= 1'b0;
        else
            coll_q <= acc_a && acc_b && wr_a && wr_b && (addr_a == addr_b);
    end

    bram_dp_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG), .WRITE_MODE(WRITE_MODE)) u_pipe_a (
        .clk(clk), .rst_n(rst_n), .acc_i(acc_a), .wr_i(wr_a), .old_i(old_a), .new_i(new_a),
        .q_o(q_a), .rvalid_o(rvalid_a)
    );

    bram_dp_rdpipe #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG), .WRITE_MODE(WRITE_MODE)) u_pipe_b (
        .clk(clk), .rst_n(rst_n), .acc_i(acc_b), .wr_i(wr_b), .old_i(old_b), .new_i(new_b),
        .q_o(q_b), .rvalid_o(rvalid_b)
    );

    assign busy      = busy_q;
    assign collision = coll_q;
endmodule

// File: tb/tb_bram_dp_param.sv
module tb_bram_dp_param;
  typedef struct {logic chk; logic [31:0] d;} exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t qa[$], qb[$], q1[$], q2[$];

  logic        clr0, en_a0, en_b0;
  logic [3:0]  we_a0, we_b0, addr_a0, addr_b0;
  logic [31:0] data_a0, data_b0, q_a0, q_b0;
  logic        rvalid_a0, rvalid_b0, busy0, coll0;

  logic        s_en, z_en;
  logic [0:0]  s_we, z_we;
  logic [3:0]  s_addr, z_addr;
  logic [7:0]  s_data, z_data;
  logic [7:0]  q_a1, q_b1, q_a2, q_b2;
  logic        rv_a1, rv_b1, busy1, coll1, rv_a2, rv_b2, busy2, coll2;

  always #5 clk = ~clk;

  bram_dp_param #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(1),
                  .WRITE_MODE(0), .CLEAR_ON_RST(1), .CLEAR_VALUE(32'h0)) u0 (
    .clk(clk), .rst_n(rst_n), .clear_req(clr0), .busy(busy0),
    .en_a(en_a0), .we_a(we_a0), .addr_a(addr_a0), .data_a(data_a0), .q_a(q_a0), .rvalid_a(rvalid_a0),
    .en_b(en_b0), .we_b(we_b0), .addr_b(addr_b0), .data_b(data_b0), .q_b(q_b0), .rvalid_b(rvalid_b0),
    .collision(coll0)
  );

  bram_dp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(0),
                  .WRITE_MODE(1), .CLEAR_ON_RST(1), .CLEAR_VALUE(8'h0)) u1 (
    .clk(clk), .rst_n(rst_n), .clear_req(z_en), .busy(busy1),
    .en_a(s_en), .we_a(s_we), .addr_a(s_addr), .data_a(s_data), .q_a(q_a1), .rvalid_a(rv_a1),
    .en_b(z_en), .we_b(z_we), .addr_b(z_addr), .data_b(z_data), .q_b(q_b1), .rvalid_b(rv_b1),
    .collision(coll1)
  );

  bram_dp_param #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .BYTE_WIDTH(8), .OUT_REG(0),
                  .WRITE_MODE(2), .CLEAR_ON_RST(1), .CLEAR_VALUE(8'h0)) u2 (
    .clk(clk), .rst_n(rst_n), .clear_req(z_en), .busy(busy2),
    .en_a(s_en), .we_a(s_we), .addr_a(s_addr), .data_a(s_data), .q_a(q_a2), .rvalid_a(rv_a2),
    .en_b(z_en), .we_b(z_we), .addr_b(z_addr), .data_b(z_data), .q_b(q_b2), .rvalid_b(rv_b2),
    .collision(coll2)
  );

  always @(negedge clk) begin
    exp_t e;
    if (rvalid_a0) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $error("FAIL u0_qa unexpected rvalid obs=%0h", q_a0);
      end else begin
        e = qa.pop_front();
        if (e.chk) begin
          checks++;
          if (q_a0 !== e.d) begin
            errors++;
            $error("FAIL u0_qa obs=%0h exp=%0h", q_a0, e.d);
          end
        end
      end
    end
    if (rvalid_b0) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $error("FAIL u0_qb unexpected rvalid obs=%0h", q_b0);
      end else begin
        e = qb.pop_front();
        if (e.chk) begin
          checks++;
          if (q_b0 !== e.d) begin
            errors++;
            $error("FAIL u0_qb obs=%0h exp=%0h", q_b0, e.d);
          end
        end
      end
    end
    if (rv_a1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $error("FAIL u1_qa unexpected rvalid obs=%0h", q_a1);
      end else begin
        e = q1.pop_front();
        if (e.chk) begin
          checks++;
          if (32'(q_a1) !== e.d) begin
            errors++;
            $error("FAIL u1_qa obs=%0h exp=%0h", q_a1, e.d);
          end
        end
      end
    end
    if (rv_a2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $error("FAIL u2_qa unexpected rvalid obs=%0h", q_a2);
      end else begin
        e = q2.pop_front();
        if (e.chk) begin
          checks++;
          if (32'(q_a2) !== e.d) begin
            errors++;
            $error("FAIL u2_qa obs=%0h exp=%0h", q_a2, e.d);
          end
        end
      end
    end
    if (rv_b1) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $error("FAIL u1_qb unexpected rvalid obs=%0h", q_b1);
      end else begin
        e = q1.pop_front();
        if (e.chk) begin
          checks++;
          if (32'(q_b1) !== e.d) begin
            errors++;
            $error("FAIL u1_qb obs=%0h exp=%0h", q_b1, e.d);
          end
        end
      end
    end
    if (rv_b2) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $error("FAIL u2_qb unexpected rvalid obs=%0h", q_b2);
      end else begin
        e = q2.pop_front();
        if (e.chk) begin
          checks++;
          if (32'(q_b2) !== e.d) begin
            errors++;
            $error("FAIL u2_qb obs=%0h exp=%0h", q_b2, e.d);
          end
        end
      end
    end
  end

  function automatic void pa(input logic c, input logic [31:0] d); qa.push_back('{c, d}); endfunction
  function automatic void pb(input logic c, input logic [31:0] d); qb.push_back('{c, d}); endfunction
  function automatic void p1(input logic [31:0] d); q1.push_back('{1'b1, d}); endfunction
  function automatic void p2(input logic [31:0] d); q2.push_back('{1'b1, d}); endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic en, input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
    en_a0 = en; we_a0 = we; addr_a0 = ad; data_a0 = d;
  endtask

  task automatic drv_b(input logic en, input logic [3:0] we, input logic [3:0] ad, input logic [31:0] d);
    en_b0 = en; we_b0 = we; addr_b0 = ad; data_b0 = d;
  endtask

  task automatic drv_s(input logic en, input logic we, input logic [3:0] ad, input logic [7:0] d);
    s_en = en; s_we = we; s_addr = ad; s_data = d;
  endtask

  task automatic idle;
    drv_a(0, 4'h0, 4'h0, 32'h0);
    drv_b(0, 4'h0, 4'h0, 32'h0);
    drv_s(0, 1'b0, 4'h0, 8'h0);
    clr0 = 1'b0;
  endtask

  task automatic wait_clear(input string tag);
    int n;
    n = 0;
    while (busy0 && n < 40) begin
      tick;
      n++;
    end
    chk(tag, n, 16);
    chk("u1_busy_done", busy1, 1'b0);
  endtask

  task automatic read_all;
    for (int i = 0; i < 16; i++) begin
      drv_a(1, 4'h0, 4'(i), 32'h0);       pa(1, 32'h0);
      drv_b(1, 4'h0, 4'(15 - i), 32'h0);  pb(1, 32'h0);
      drv_s(1, 1'b0, 4'(i), 8'h0);        p1(32'h0); p2(32'h0);
      tick;
    end
    idle;
    repeat (3) tick;
  endtask

  initial begin
    z_en = 1'b0; z_we = 1'b0; z_addr = 4'h0; z_data = 8'h0;
    idle;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q_a", q_a0, 32'h0);
    chk("rst_q_b", q_b0, 32'h0);
    chk("rst_rvalid_a", rvalid_a0, 1'b0);
    chk("rst_rvalid_b", rvalid_b0, 1'b0);
    chk("rst_collision", coll0, 1'b0);
    chk("rst_busy", busy0, 1'b1);
    rst_n = 1'b1;

    wait_clear("t1_sweep_len");
    read_all;

    drv_a(1, 4'hF, 4'h5, 32'h42); pa(1, 32'h42);
    tick; idle;
    drv_b(1, 4'h0, 4'h5, 32'h0); pb(1, 32'h42);
    tick; idle;
    chk("t2_rvalid_b_early", rvalid_b0, 1'b0);
    tick;
    chk("t2_rvalid_b", rvalid_b0, 1'b1);
    chk("t2_q_b", q_b0, 32'h42);
    repeat (2) tick;

    drv_a(1, 4'hF, 4'h3, 32'hAABBCCDD); pa(1, 32'hAABBCCDD);
    tick;
    drv_a(1, 4'b0010, 4'h3, 32'h00001100); pa(1, 32'hAABB11DD);
    tick;
    drv_a(1, 4'h0, 4'h3, 32'h0); pa(1, 32'hAABB11DD);
    drv_b(1, 4'h0, 4'h3, 32'h0); pb(1, 32'hAABB11DD);
    tick; idle;
    repeat (3) tick;

    drv_s(1, 1'b1, 4'h7, 8'h11); p1(32'h0);
    tick;
    drv_s(1, 1'b0, 4'h7, 8'h0); p1(32'h11); p2(32'h11);
    tick;
    drv_s(1, 1'b1, 4'h7, 8'h22); p1(32'h11);
    tick; idle;
    chk("t4_nc_rvalid", rv_a2, 1'b0);
    chk("t4_nc_q_hold", q_a2, 8'h11);
    tick;
    chk("t4_rf_q", q_a1, 8'h11);
    drv_s(1, 1'b0, 4'h7, 8'h0); p1(32'h22); p2(32'h22);
    tick; idle;
    repeat (2) tick;

    drv_a(1, 4'hF, 4'h0, 32'h0C); pa(1, 32'h0C);
    drv_b(1, 4'hF, 4'h0, 32'h28); pb(0, 32'h0);
    tick; idle;
    chk("t5_collision", coll0, 1'b1);
    drv_a(1, 4'h0, 4'h0, 32'h0); pa(1, 32'h0C);
    tick; idle;
    chk("t5_collision_clr", coll0, 1'b0);
    repeat (2) tick;
    drv_a(1, 4'b0001, 4'h1, 32'h000000AA); pa(0, 32'h0);
    drv_b(1, 4'b0011, 4'h1, 32'h0000BBCC); pb(0, 32'h0);
    tick; idle;
    chk("t5_part_collision", coll0, 1'b1);
    drv_b(1, 4'h0, 4'h1, 32'h0); pb(1, 32'h0000BBAA);
    tick; idle;
    drv_a(1, 4'hF, 4'h8, 32'h11111111); pa(1, 32'h11111111);
    drv_b(1, 4'hF, 4'h9, 32'h22222222); pb(1, 32'h22222222);
    tick; idle;
    chk("t5_no_collision", coll0, 1'b0);
    drv_a(1, 4'h0, 4'h8, 32'h0);         pa(1, 32'h11111111);
    drv_b(1, 4'hF, 4'h8, 32'h33333333);  pb(1, 32'h33333333);
    tick;
    drv_a(1, 4'h0, 4'h8, 32'h0);         pa(1, 32'h33333333);
    drv_b(1, 4'h0, 4'h9, 32'h0);         pb(1, 32'h22222222);
    tick; idle;
    repeat (3) tick;

    clr0 = 1'b1;
    drv_a(1, 4'h0, 4'h3, 32'h0); pa(1, 32'hAABB11DD);
    tick; idle;
    chk("t6_busy", busy0, 1'b1);
    drv_a(1, 4'h0, 4'h3, 32'h0);
    drv_b(1, 4'h0, 4'h3, 32'h0);
    repeat (3) tick;
    idle;
    chk("t6_q_hold", q_a0, 32'hAABB11DD);
    chk("t6_rvalid_sweep", rvalid_a0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_q", q_a0, 32'h0);
    chk("t6_rst_busy", busy0, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_clear("t6_sweep_len");
    read_all;

    repeat (4) tick;
    chk("end_qa_empty", qa.size(), 0);
    chk("end_qb_empty", qb.size(), 0);
    chk("end_q1_empty", q1.size(), 0);
    chk("end_q2_empty", q2.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
